// File: rtl/piso_serial_tx_pkg.sv
// piso_serial_tx_pkg
//   Shared types and constants for the parallel-in, serial-out transmitter.
//   - tx_state_t    : two-state frame FSM encoding
//   - DEFAULT_WIDTH : default word width in bits
//   - cnt_width()   : bit-counter width for a given word width
package piso_serial_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter runs WIDTH-1 down to 0, so $clog2(WIDTH) bits are enough.
    // Guarded so a degenerate width still yields a legal 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serial_tx.sv
// piso_serial_tx
//   Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word on a
//   READY/LOAD handshake and shifts it out one bit per clock edge on which
//   SHIFT_EN is high. All outputs are registered.
//
// Ports:
//   CLK        in   rising-edge clock
//   CLR        in   synchronous active-high reset, highest priority
//   DIN        in   parallel word, sampled only on an accepting edge
//   LOAD       in   word-valid request from upstream
//   READY      out  idle and able to accept a word
//   SHIFT_EN   in   bit-rate strobe; frame advances only on these edges
//   SOUT       out  serial data
//   SOUT_VALID out  SOUT carries a frame bit
//   FIRST      out  SOUT carries the first bit of the frame
//   DONE       out  one-cycle pulse when the last bit retires
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    output logic             READY,
    input  logic             SHIFT_EN,
    output logic             SOUT,
    output logic             SOUT_VALID,
    output logic             FIRST,
    output logic             DONE
);

    localparam int             CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

    tx_state_t        r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;
    logic             r_sout;
    logic             r_valid;
    logic             r_first;
    logic             r_done;

    logic [WIDTH-1:0] w_shreg_nxt;
    logic             w_next_bit;
    logic             w_first_bit;

    // The bit currently on SOUT is always the head of r_shreg, so the next
    // bit to present is the one adjacent to the head.
    always_comb begin
        w_shreg_nxt = r_shreg;
        w_next_bit  = 1'b0;
        w_first_bit = 1'b0;
        if (MSB_FIRST) begin
            w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
            w_next_bit  = r_shreg[WIDTH-2];
            w_first_bit = DIN[WIDTH-1];
        end else begin
            w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
            w_next_bit  = r_shreg[1];
            w_first_bit = DIN[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (LOAD) begin
                        r_shreg <= DIN;
                        r_sout  <= w_first_bit;
                        r_valid <= 1'b1;
                        r_first <= 1'b1;
                        r_ready <= 1'b0;
                        r_cnt   <= CNT_MAX;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Without SHIFT_EN everything holds, keeping the bit
                    // stable for the receiver's sampling window.
                    if (SHIFT_EN) begin
                        r_first <= 1'b0;
                        if (r_cnt != '0) begin
                            r_shreg <= w_shreg_nxt;
                            r_sout  <= w_next_bit;
                            r_cnt   <= r_cnt - 1'b1;
                        end else begin
                            // Last bit retires; leaving here at zero means
                            // the counter never underflows.
                            r_shreg <= '0;
                            r_sout  <= 1'b0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign READY      = r_ready;
    assign SOUT       = r_sout;
    assign SOUT_VALID = r_valid;
    assign FIRST      = r_first;
    assign DONE       = r_done;

endmodule

// File: tb/tb_piso_serial_tx.sv
module tb_piso_serial_tx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         CLR;
    logic [W-1:0] DIN;
    logic         LOAD;
    logic         SHIFT_EN;

    logic rdy_m, sout_m, vld_m, first_m, done_m;
    logic rdy_l, sout_l, vld_l, first_l, done_l;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .CLK(CLK), .CLR(CLR), .DIN(DIN), .LOAD(LOAD), .READY(rdy_m),
        .SHIFT_EN(SHIFT_EN), .SOUT(sout_m), .SOUT_VALID(vld_m),
        .FIRST(first_m), .DONE(done_m)
    );

    piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(CLK), .CLR(CLR), .DIN(DIN), .LOAD(LOAD), .READY(rdy_l),
        .SHIFT_EN(SHIFT_EN), .SOUT(sout_l), .SOUT_VALID(vld_l),
        .FIRST(first_l), .DONE(done_l)
    );

    // {READY, SOUT, SOUT_VALID, FIRST, DONE}
    wire [4:0] ob_m = {rdy_m, sout_m, vld_m, first_m, done_m};
    wire [4:0] ob_l = {rdy_l, sout_l, vld_l, first_l, done_l};

    // Frame-level reference: busy flag, index of the bit on the line, word.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_idx  = 0;
    logic [W-1:0] m_word = '0;

    always @(posedge CLK) begin
        if (CLR) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_idx  <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (LOAD) begin
                m_busy <= 1'b1;
                m_word <= DIN;
                m_idx  <= 0;
            end
        end else begin
            m_done <= 1'b0;
            if (SHIFT_EN) begin
                if (m_idx == W - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    function automatic logic [4:0] exp_vec(input bit msb);
        logic s;
        s = 1'b0;
        if (m_busy) s = msb ? m_word[W-1-m_idx] : m_word[m_idx];
        return {~m_busy, s, m_busy, m_busy && (m_idx == 0), m_done};
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Sends one word with SHIFT_EN high one cycle in 'period'; optionally
    // offers LOAD with the inverted word for 'busy_loads' cycles mid-frame.
    // Returns bits as seen on each DUT (first bit ends in the MSB), the
    // cycle offset of DONE, and the LSB DUT's SOUT_VALID cycle count.
    task automatic run_frame(input logic [W-1:0] w, input int period,
                             input int busy_loads,
                             output logic [W-1:0] gm, output logic [W-1:0] gl,
                             output int dk, output int vcnt);
        gm = '0; gl = '0; dk = -1; vcnt = 0;
        DIN = w; LOAD = 1'b1; SHIFT_EN = 1'b0;
        tick();
        LOAD = 1'b0;
        n_chk++;
        if (ob_m !== exp_vec(1'b1) || ob_l !== exp_vec(1'b0))
            $display("FAIL accept_%h: msb %b lsb %b expected %b / %b",
                     w, ob_m, ob_l, exp_vec(1'b1), exp_vec(1'b0));
        else n_pass++;
        gm = {gm[W-2:0], sout_m};
        gl = {gl[W-2:0], sout_l};
        vcnt += int'(vld_l);
        for (int k = 1; k <= W * period + 4; k++) begin
            SHIFT_EN = (k % period == 0);
            if (k <= busy_loads) begin LOAD = 1'b1; DIN = ~w; end
            else LOAD = 1'b0;
            tick();
            n_chk++;
            if (ob_m !== exp_vec(1'b1) || ob_l !== exp_vec(1'b0))
                $display("FAIL frame_%h_k%0d: msb %b lsb %b expected %b / %b",
                         w, k, ob_m, ob_l, exp_vec(1'b1), exp_vec(1'b0));
            else n_pass++;
            vcnt += int'(vld_l);
            if (SHIFT_EN && vld_m) gm = {gm[W-2:0], sout_m};
            if (SHIFT_EN && vld_l) gl = {gl[W-2:0], sout_l};
            if (done_m) begin dk = k; break; end
        end
        LOAD = 1'b0; SHIFT_EN = 1'b0;
        n_chk++;
        if (dk < 0) $display("FAIL frame_%h_timeout: no DONE seen", w);
        else n_pass++;
    endtask

    task automatic test_reset();
        CLR = 1'b1; LOAD = 1'b0; SHIFT_EN = 1'b0; DIN = '0;
        tick(); tick();
        CLR = 1'b0;
        tick();
        n_chk++;
        if (ob_m !== 5'b10000) $display("FAIL reset_msb: got %b want 10000", ob_m);
        else n_pass++;
        n_chk++;
        if (ob_l !== 5'b10000) $display("FAIL reset_lsb: got %b want 10000", ob_l);
        else n_pass++;
    endtask

    task automatic test_full_rate();
        logic [W-1:0] gm, gl;
        int dk, vc;
        run_frame(8'h1E, 1, 0, gm, gl, dk, vc);
        n_chk++;
        if (gm !== 8'h1E) $display("FAIL msb_seq: got %h want 1e", gm); else n_pass++;
        n_chk++;
        if (gl !== 8'h78) $display("FAIL lsb_seq: got %h want 78", gl); else n_pass++;
        n_chk++;
        if (dk !== W) $display("FAIL done_latency: got %0d want %0d", dk, W); else n_pass++;
        n_chk++;
        if (vc !== W) $display("FAIL valid_cycles: got %0d want %0d", vc, W); else n_pass++;
        n_chk++;
        if (!(rdy_m && rdy_l && done_l))
            $display("FAIL done_ready: rdy %b%b done_l %b want 111", rdy_m, rdy_l, done_l);
        else n_pass++;
        tick();
        n_chk++;
        if (done_m !== 1'b0 || done_l !== 1'b0 || rdy_m !== 1'b1)
            $display("FAIL done_pulse: done %b%b rdy %b want 00 1", done_m, done_l, rdy_m);
        else n_pass++;
    endtask

    task automatic test_paced();
        logic [W-1:0] gm, gl;
        int dk, vc;
        run_frame(8'hA5, 4, 0, gm, gl, dk, vc);
        n_chk++;
        if (gm !== 8'hA5) $display("FAIL paced_seq: got %h want a5", gm); else n_pass++;
        n_chk++;
        if (dk !== 32) $display("FAIL paced_done: got %0d want 32", dk); else n_pass++;
        n_chk++;
        if (vc !== 32) $display("FAIL paced_valid: got %0d want 32", vc); else n_pass++;
    endtask

    task automatic test_busy_load();
        logic [W-1:0] gm, gl;
        int dk, vc;
        run_frame(8'hFF, 1, 3, gm, gl, dk, vc);
        n_chk++;
        if (gm !== 8'hFF) $display("FAIL busy_seq: got %h want ff", gm); else n_pass++;
        run_frame(8'h00, 1, 0, gm, gl, dk, vc);
        n_chk++;
        if (gm !== 8'h00 || gl !== 8'h00)
            $display("FAIL after_busy: got %h/%h want 00/00", gm, gl);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [W-1:0] gm, gl;
        int dk, vc;
        DIN = 8'hF0; LOAD = 1'b1; SHIFT_EN = 1'b1;
        tick();
        LOAD = 1'b0;
        tick(); tick();
        n_chk++;
        if (sout_m !== 1'b1 || vld_m !== 1'b1 || sout_l !== 1'b0)
            $display("FAIL abort_bit3: sout %b%b vld %b want 1 0 1", sout_m, sout_l, vld_m);
        else n_pass++;
        CLR = 1'b1;
        tick();
        CLR = 1'b0; SHIFT_EN = 1'b0;
        n_chk++;
        if (ob_m !== 5'b10000 || ob_l !== 5'b10000)
            $display("FAIL abort_reset: got %b/%b want 10000", ob_m, ob_l);
        else n_pass++;
        tick();
        n_chk++;
        if (done_m !== 1'b0 || done_l !== 1'b0)
            $display("FAIL abort_nodone: got %b%b want 00", done_m, done_l);
        else n_pass++;
        run_frame(8'h0F, 1, 0, gm, gl, dk, vc);
        n_chk++;
        if (gm !== 8'h0F || dk !== W)
            $display("FAIL abort_next: got %h dk %0d want 0f dk %0d", gm, dk, W);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        // LOAD held high throughout: the retiring edge must not accept.
        DIN = 8'h3C; LOAD = 1'b1; SHIFT_EN = 1'b1;
        for (int c = 0; c < 3 * (W + 2); c++) begin
            if (c == W + 1) DIN = 8'hC3;
            tick();
            n_chk++;
            if (ob_m !== exp_vec(1'b1) || ob_l !== exp_vec(1'b0))
                $display("FAIL b2b_c%0d: got %b/%b want %b/%b",
                         c, ob_m, ob_l, exp_vec(1'b1), exp_vec(1'b0));
            else n_pass++;
        end
        LOAD = 1'b0;
        for (int c = 0; c < W + 2; c++) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            CLR      = ($urandom_range(0, 99) == 0);
            LOAD     = ($urandom_range(0, 2) == 0);
            SHIFT_EN = $urandom_range(0, 1) == 1;
            DIN      = W'($urandom);
            tick();
            n_chk++;
            if (ob_m !== exp_vec(1'b1) || ob_l !== exp_vec(1'b0))
                $display("FAIL rand_c%0d: got %b/%b want %b/%b",
                         c, ob_m, ob_l, exp_vec(1'b1), exp_vec(1'b0));
            else n_pass++;
        end
        CLR = 1'b0; LOAD = 1'b0; SHIFT_EN = 1'b0;
    endtask

    initial begin
        CLR = 1'b1; LOAD = 1'b0; SHIFT_EN = 1'b0; DIN = '0;
        @(negedge CLK);
        test_reset();
        test_full_rate();
        test_paced();
        test_busy_load();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word through a ready/load handshake and shifts it out one bit per enabled clock edge. It is the transmit end of the team's serial link, driving the D-FF-based serial-in capture chain on the receive side. Bit pacing comes from an external SHIFT_EN strobe, so one clock domain can serve any bit rate.

Parameters:
WIDTH, 8, bits per word (minimum 2)
MSB_FIRST, 1, 1 = transmit DIN[WIDTH-1] first; 0 = transmit DIN[0] first

Ports:
CLK  input  1  rising-edge clock; the only clock
CLR  input  1  reset, synchronous and active-high
DIN  input  WIDTH  parallel word, sampled only on an accepting edge
LOAD  input  1  word-valid request from the upstream source
READY  output  1  high while idle and able to accept a word
SHIFT_EN  input  1  bit-rate strobe; advances the frame on edges where it is high
SOUT  output  1  serial data out
SOUT_VALID  output  1  high while SOUT carries a frame bit
FIRST  output  1  high while SOUT carries bit 0 of the frame
DONE  output  1  one-cycle pulse when the last bit retires

Behaviour:
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Reset (CLR=1 at a rising edge): state IDLE, READY=1, SOUT=0, SOUT_VALID=0, FIRST=0, DONE=0, bit counter=0, shift register=0.
- CLR has priority over every other input in the same cycle.
- Two states: IDLE and SHIFT.
- IDLE:
  - READY=1, SOUT=0, SOUT_VALID=0.
  - SHIFT_EN is ignored.
  - Edge with LOAD=1: capture DIN into the shift register.
  - On that edge: SOUT <= first bit (per MSB_FIRST), SOUT_VALID <= 1, FIRST <= 1, READY <= 0, counter <= WIDTH-1, next state SHIFT.
- SHIFT:
  - LOAD is ignored and DIN is not sampled. There is no overwrite or queueing of a word offered while busy.
  - Edge with SHIFT_EN=0: all outputs and state hold.
  - Edge with SHIFT_EN=1 and counter>0: shift one position, SOUT <= next bit, counter decrements, FIRST <= 0.
  - Edge with SHIFT_EN=1 and counter==0: SOUT <= 0, SOUT_VALID <= 0, FIRST <= 0, DONE <= 1, READY <= 1, next state IDLE.
- DONE is high for exactly one cycle and cleared on the following edge.
- Latency with SHIFT_EN held high: word accepted at edge N.
  - SOUT_VALID is high for exactly WIDTH cycles, after edges N through N+WIDTH-1.
  - DONE and READY are high after edge N+WIDTH.
  - The earliest next accept is edge N+WIDTH+1, giving a minimum one-cycle gap between frames.
- Each frame bit is held stable from the edge that presents it until the next SHIFT_EN edge. The receiver samples during that window.
- Counter width is $clog2(WIDTH) bits and never wraps. Leaving SHIFT at counter==0 prevents underflow.
- CLR asserted mid-frame aborts the frame: no DONE pulse, return to reset values, remaining bits discarded.
- LOAD high on the same edge as the final bit retires is ignored, because READY is still 0. The source must keep LOAD high to be accepted next cycle.

Decomposition:
- Shared package holds:
  - state enum tx_state_t {IDLE, SHIFT}
  - default WIDTH constant
  - counter-width function based on $clog2
- Single module; no sub-module is warranted. The shift register, counter and two-state FSM fit in one always block plus output registers.

Test Plan:
1. Reset check: CLR=1 for 2 cycles, then release -> READY=1, SOUT=0, SOUT_VALID=0, FIRST=0, DONE=0.
2. MSB-first frame: WIDTH=8, MSB_FIRST=1, SHIFT_EN=1, DIN=0x1E with LOAD for one cycle.
   - SOUT = 0,0,0,1,1,1,1,0 over 8 cycles; FIRST high only on the first bit.
   - DONE pulses once after the 8th bit; READY returns to 1.
3. LSB-first frame: MSB_FIRST=0, DIN=0x1E -> SOUT = 0,1,1,1,1,0,0,0; SOUT_VALID high for exactly 8 cycles.
4. Paced shift: SHIFT_EN high one cycle in four, DIN=0xA5, MSB first.
   - Each bit holds for 4 cycles; output sequence is 1,0,1,0,0,1,0,1.
   - DONE occurs 32 cycles after the accept edge.
5. Load while busy: during a 0xFF frame, assert LOAD with DIN=0x00 for 3 cycles.
   - Transmitted bits remain all 1. After DONE, a new LOAD with 0x00 sends eight 0s.
6. Abort: CLR=1 after the 3rd bit of a 0xF0 frame.
   - Next cycle shows reset values and no DONE pulse. A subsequent LOAD of 0x0F transmits a full, clean 8-bit frame.
